// File: rtl/auth_session_ctrl.sv
// Session controller around the 4-button password authenticator: re-arms it after each
// result, counts consecutive failures, enforces a lockout window and aborts stale entries.
module auth_session_ctrl #(
  parameter int unsigned MaxFails      = 3,
  parameter int unsigned GrantCycles   = 8,
  parameter int unsigned LockCycles    = 16,
  parameter int unsigned TimeoutCycles = 32,
  parameter int unsigned TmrW          = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       auth_ok_i,
  input  logic       auth_err_i,
  input  logic       any_press_i,
  output logic       auth_clr_o,
  output logic       unlock_o,
  output logic       locked_o,
  output logic [1:0] fail_cnt_o,
  output logic [6:0] ssg_d_o
);

  // Terminal timer values; the timer is a down-counter in GRANT/LOCKOUT and an up-counter
  // measuring inactivity in ARMED.
  localparam logic [TmrW-1:0] GrantLast   = TmrW'(GrantCycles - 1);
  localparam logic [TmrW-1:0] LockLast    = TmrW'(LockCycles - 1);
  localparam logic [TmrW-1:0] TimeoutLast = TmrW'(TimeoutCycles - 1);
  localparam logic [1:0]      FailLimit   = 2'(MaxFails);
  localparam logic [1:0]      FailSat     = 2'd3;

  // Active-low glyphs, bit order gfedcba.
  localparam logic [6:0] GlyphDash  = 7'b0111111;
  localparam logic [6:0] GlyphP     = 7'b0001100;
  localparam logic [6:0] GlyphL     = 7'b1000111;
  localparam logic [6:0] GlyphBlank = 7'b1111111;

  typedef enum logic [2:0] {
    StArmed,
    StGrant,
    StFail,
    StClear,
    StLockout
  } state_e;

  state_e          state_q, state_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic            entry_active_q, entry_active_d;
  logic [1:0]      fail_cnt_q, fail_cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StArmed;
      timer_q        <= '0;
      entry_active_q <= 1'b0;
      fail_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      entry_active_q <= entry_active_d;
      fail_cnt_q     <= fail_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    entry_active_d = entry_active_q;
    fail_cnt_d     = fail_cnt_q;

    unique case (state_q)
      StArmed: begin
        // Error outranks success so a glitchy double-assert never grants access.
        if (auth_err_i) begin
          state_d = StFail;
          if (fail_cnt_q != FailSat) begin
            fail_cnt_d = fail_cnt_q + 2'd1;
          end
        end else if (auth_ok_i) begin
          state_d    = StGrant;
          fail_cnt_d = '0;
          timer_d    = GrantLast;
        end else if (any_press_i) begin
          entry_active_d = 1'b1;
          timer_d        = '0;
        end else if (entry_active_q) begin
          if (timer_q == TimeoutLast) begin
            state_d = StClear;
          end else begin
            timer_d = timer_q + TmrW'(1);
          end
        end
      end

      StGrant: begin
        if (timer_q == '0) begin
          state_d = StClear;
        end else begin
          timer_d = timer_q - TmrW'(1);
        end
      end

      StFail: begin
        if (fail_cnt_q >= FailLimit) begin
          state_d = StLockout;
          timer_d = LockLast;
        end else begin
          state_d = StClear;
        end
      end

      StLockout: begin
        if (timer_q == '0) begin
          state_d    = StClear;
          fail_cnt_d = '0;
        end else begin
          timer_d = timer_q - TmrW'(1);
        end
      end

      StClear: begin
        state_d        = StArmed;
        entry_active_d = 1'b0;
        timer_d        = '0;
      end

      default: begin
        state_d = StArmed;
      end
    endcase
  end

  always_comb begin
    auth_clr_o = 1'b0;
    unlock_o   = 1'b0;
    locked_o   = 1'b0;
    ssg_d_o    = GlyphBlank;

    unique case (state_q)
      StArmed: begin
        ssg_d_o = GlyphDash;
      end
      StGrant: begin
        unlock_o = 1'b1;
        ssg_d_o  = GlyphP;
      end
      StLockout: begin
        // Holding the authenticator in reset makes presses inert during the window.
        locked_o   = 1'b1;
        auth_clr_o = 1'b1;
        ssg_d_o    = GlyphL;
      end
      StClear: begin
        auth_clr_o = 1'b1;
      end
      default: begin
        ssg_d_o = GlyphBlank;
      end
    endcase
  end

  assign fail_cnt_o = fail_cnt_q;

endmodule
